booth_r4_seq_mult: RTL and testbench

//   Sequential radix-4 Booth multiplier, N x N -> 2N. Successor to the combinational unsigned Booth block.

---
 rtl/booth_pkg.sv | 30 +++
 rtl/booth_r4_enc.sv | 23 ++
 rtl/booth_r4_seq_mult.sv | 186 ++++++++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth sequential multiplier.
// Optional feature macro used by the multiplier: BOOTH_EARLY_TERM_EN.
package booth_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth digit select: magnitude one-hot (one/two, both low = zero) plus sign.
  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_digit_t;

  // Internal extended operand width: always even and at least N+1, so the
  // unsigned top bit of an operand never reads as a sign bit.
  function automatic int calc_w(input int n);
    return ((n % 32'sd2) == 32'sd0) ? (n + 32'sd2) : (n + 32'sd1);
  endfunction

  // Number of radix-4 iterations (two multiplier bits each).
  function automatic int calc_iter(input int n);
    return calc_w(n) / 32'sd2;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a digit select in {0, +A, +2A, -A, -2A}.
import booth_pkg::*;

module booth_r4_enc (
  input  logic [2:0]   win,
  output booth_digit_t digit
);

  // Standard Booth recoding table.
  always_comb begin
    digit = '0;
    case (win)
      3'b000, 3'b111: digit = '{neg: 1'b0, two: 1'b0, one: 1'b0};
      3'b001, 3'b010: digit = '{neg: 1'b0, two: 1'b0, one: 1'b1};
      3'b011:         digit = '{neg: 1'b0, two: 1'b1, one: 1'b0};
      3'b100:         digit = '{neg: 1'b1, two: 1'b1, one: 1'b0};
      3'b101, 3'b110: digit = '{neg: 1'b1, two: 1'b0, one: 1'b1};
      default:        digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, N x N -> 2N, signed or unsigned per
// operation, valid/ready on both sides, two multiplier bits retired per clock.
// Optional macro BOOTH_EARLY_TERM_EN: leave BUSY as soon as the remaining
// multiplier bits can only produce zero digits.
import booth_pkg::*;

module booth_r4_seq_mult #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   product,
  output logic             busy
);

  localparam int W    = calc_w(N);
  localparam int ITER = calc_iter(N);
  localparam int AW   = 2 * W + 1;
  localparam int CW   = $clog2(ITER + 1);

  // Registered state.
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  // Multiplier with the look-behind bit in position 0; shifted right by two
  // per iteration so the current window is always bits [2:0].
  logic [W:0]       mult_q, mult_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  // Combinational datapath.
  booth_digit_t     digit_s;
  logic             ext_a_s, ext_b_s;
  logic [W-1:0]     a_ext_s, b_ext_s;
  logic [W:0]       a_one_s, a_two_s, pp_mag_s, pp_s, upper_sum_s;
  logic [AW-1:0]    acc_add_s, acc_step_s;
  logic [2*N-1:0]   acc_fin_s;
  logic             finish_s;
`ifdef BOOTH_EARLY_TERM_EN
  localparam int SW = $clog2(AW);
  logic [SW-1:0]    shamt_s;
  logic             uniform_s;
`endif

  booth_r4_enc u_enc (
    .win   (mult_q[2:0]),
    .digit (digit_s)
  );

  // Operand extension to W bits; the sign fill is gated by the mode bit.
  always_comb begin
    ext_a_s = in_signed & a[N-1];
    ext_b_s = in_signed & b[N-1];
    a_ext_s = {{(W-N){ext_a_s}}, a};
    b_ext_s = {{(W-N){ext_b_s}}, b};
  end

  // One Booth step: select +-A/+-2A, add into the upper W+1 bits, shift by two.
  always_comb begin
    a_one_s = {a_q[W-1], a_q};
    a_two_s = {a_q, 1'b0};
    if (digit_s.two) begin
      pp_mag_s = a_two_s;
    end else if (digit_s.one) begin
      pp_mag_s = a_one_s;
    end else begin
      pp_mag_s = '0;
    end
    if (digit_s.neg) begin
      pp_s = -pp_mag_s;
    end else begin
      pp_s = pp_mag_s;
    end
    upper_sum_s = acc_q[AW-1:W] + pp_s;
    acc_add_s   = {upper_sum_s, acc_q[W-1:0]};
    acc_step_s  = $signed(acc_add_s) >>> 2'd2;
  end

`ifdef BOOTH_EARLY_TERM_EN
  // Finish once the unconsumed bits (look-behind included) are all-0 or
  // all-1; the skipped iterations' shifts are applied in one go. The first
  // BUSY cycle always runs a real iteration, keeping latency in 2..ITER+1.
  always_comb begin
    uniform_s = (mult_q == '0) || (mult_q == '1);
    finish_s  = (cnt_q == CW'(ITER)) || ((cnt_q != '0) && uniform_s);
    shamt_s   = SW'((ITER - int'(cnt_q)) * 32'sd2);
    acc_fin_s = (2*N)'($signed(acc_q) >>> shamt_s);
  end
`else
  // Fixed schedule: ITER iterations, then one cycle to publish the result.
  always_comb begin
    finish_s  = (cnt_q == CW'(ITER));
    acc_fin_s = acc_q[2*N-1:0];
  end
`endif

  // Controller next-state and register next-values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    mult_d      = mult_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_ext_s;
          mult_d  = {b_ext_s, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (finish_s) begin
          product_d   = acc_fin_s;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          acc_d  = acc_step_s;
          mult_d = $signed(mult_q) >>> 2'd2;
          cnt_d  = cnt_q + CW'(1'b1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      mult_q      <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      mult_q      <= mult_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult: directed corner cases, stall and
// reset scenarios, then random operands in both modes against an arithmetic
// reference (product and latency).
module tb_booth_r4_seq_mult;

  localparam int N    = 8;
  localparam int W    = (N % 2 == 0) ? N + 2 : N + 1;
  localparam int ITER = W / 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_signed = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] product;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;

  booth_r4_seq_mult #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference product: plain integer multiply, truncated to 2N bits.
  function automatic logic [2*N-1:0] exp_product(input logic [N-1:0] av, input logic [N-1:0] bv,
                                                  input logic sv);
    longint p;
    logic [63:0] p64;
    if (sv) p = longint'($signed(av)) * longint'($signed(bv));
    else    p = longint'(av) * longint'(bv);
    p64 = p;
    return p64[2*N-1:0];
  endfunction

  // Reference latency: ITER+1, or with early exit the first k>=1 at which
  // the multiplier (with a zero appended below) shifted right by 2k is 0 or -1.
  function automatic int exp_latency(input logic [N-1:0] bv, input logic sv);
`ifdef BOOTH_EARLY_TERM_EN
    longint bval;
    longint bx;
    if (sv) bval = longint'($signed(bv));
    else    bval = longint'(bv);
    bx = bval * 2;
    for (int k = 1; k <= ITER; k++) begin
      if (((bx >>> (2 * k)) == 0) || ((bx >>> (2 * k)) == -1)) return k + 1;
    end
    return ITER + 1;
`else
    if (sv) return ITER + 1;
    else    return ITER + 1 + int'(bv == bv) - 1;
`endif
  endfunction

  // One full transaction: accept, latency, product, optional DONE stall
  // (with ignored in_valid pulses), release.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic sv, input int stall, input logic poke);
    int lat;
    logic [2*N-1:0] ep;
    ep  = exp_product(av, bv, sv);
    lat = 0;
    while (in_ready !== 1'b1 && lat < 50) begin
      step();
      lat++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'(1'b1));
    in_valid = 1'b1; a = av; b = bv; in_signed = sv;
    step();
    in_valid = 1'b0;
    a = N'($urandom()); b = N'($urandom()); in_signed = 1'($urandom());
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * ITER) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(av, sv)));
    check({tag, " product"}, 64'(product), 64'(ep));
    for (int i = 0; i < stall; i++) begin
      in_valid = poke & 1'(i);
      step();
      if (poke) begin
        check({tag, " stall out_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, " stall product"}, 64'(product), 64'(ep));
        check({tag, " stall in_ready"}, 64'(in_ready), 64'(1'b0));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " release out_valid"}, 64'(out_valid), 64'(1'b0));
    check({tag, " release in_ready"}, 64'(in_ready), 64'(1'b1));
  endtask

  initial begin
    logic [N-1:0] ones, smin, smax, one, five, three, av, bv;
    ones  = '1;
    smin  = {1'b1, {(N-1){1'b0}}};
    smax  = {1'b0, {(N-1){1'b1}}};
    one   = N'(1);
    three = N'(3);
    five  = N'(5);

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    check("reset in_ready", 64'(in_ready), 64'(1'b1));
    check("reset busy", 64'(busy), 64'(1'b0));
    check("reset out_valid", 64'(out_valid), 64'(1'b0));
    check("reset product", 64'(product), 64'(0));
    rst_n = 1'b1;
    step();

    // Directed corner operands.
    run_op("u max*max", ones, ones, 1'b0, 0, 1'b0);
    run_op("s min*min", smin, smin, 1'b1, 0, 1'b0);
    run_op("s -1*max", ones, smax, 1'b1, 0, 1'b0);
    run_op("s min*max", smin, smax, 1'b1, 0, 1'b0);
    run_op("u 3*1", three, one, 1'b0, 0, 1'b0);
    run_op("s 5*-1", five, ones, 1'b1, 0, 1'b0);
    run_op("u 0*0", '0, '0, 1'b0, 0, 1'b0);

    // Long DONE stall with ignored in_valid pulses.
    run_op("stall10", smax, ones, 1'b0, 10, 1'b1);

    // Reset during the third BUSY cycle aborts the operation.
    in_valid = 1'b1; a = five; b = smin; in_signed = 1'b0;
    step();
    in_valid = 1'b0;
    check("abort busy", 64'(busy), 64'(1'b1));
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort out_valid", 64'(out_valid), 64'(1'b0));
    check("abort product", 64'(product), 64'(0));
    check("abort in_ready", 64'(in_ready), 64'(1'b1));
    check("abort busy low", 64'(busy), 64'(1'b0));
    run_op("after abort", smax, three, 1'b1, 1, 1'b0);

    // Random operands, both modes, random output stalls.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        av = N'($urandom());
        bv = N'($urandom());
        run_op(m == 0 ? "rand u" : "rand s", av, bv, 1'(m), int'($urandom_range(0, 3)), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
